rf_write_buffer: RTL and testbench



---
 rtl/rfwb_pkg.sv | 13 +
 rtl/rfwb_fifo.sv | 71 +++++++
 rtl/rf_write_buffer.sv | 105 ++++++++++
 tb/tb_rf_write_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rfwb_pkg.sv
// Shared constants and the write-request record for the register-file write buffer.
package rfwb_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rfwb_fifo.sv
// Small circular FIFO holding pending register-file write requests.
// Caller guarantees push only when not full and pop only when not empty.
// With RFWB_FWD_EN defined the raw storage and head pointer are exported
// so the top level can search pending entries.
module rfwb_fifo
    import rfwb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(wr_req_t)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef RFWB_FWD_EN
    ,
    output logic [W-1:0]             entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] head_ptr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[head];

`ifdef RFWB_FWD_EN
    assign entries  = mem;
    assign head_ptr = head;
`endif

    // Storage is not reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// Write-request buffer in front of the 8 x 32 register file write port.
// Requests are queued in rfwb_fifo and drained at most one per cycle through
// a registered we/wAddr/wData stage. Defining RFWB_FWD_EN adds a combinational
// lookup (fwd_addr/fwd_hit/fwd_data) returning the newest pending value for an
// address, so readers can see writes that have not yet reached the file.
module rf_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = rfwb_pkg::ADDR_W,
    parameter int DATA_W = rfwb_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   drain_en,
    output logic                   we,
    output logic [ADDR_W-1:0]      wAddr,
    output logic [DATA_W-1:0]      wData,
    output logic [$clog2(DEPTH):0] count
`ifdef RFWB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]      fwd_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head_entry;

    // Ready depends only on occupancy, so a pop while full frees space one cycle later.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = drain_en && !empty;

`ifdef RFWB_FWD_EN
    logic [ENT_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] slot;
`endif

    rfwb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .wr_data  ({in_addr, in_data}),
        .rd_data  (head_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef RFWB_FWD_EN
        ,
        .entries  (entries),
        .head_ptr (head_ptr)
`endif
    );

    // Registered write port: head entry is presented one edge after it is popped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we    <= 1'b0;
            wAddr <= '0;
            wData <= '0;
        end else begin
            we <= pop;
            if (pop) begin
                {wAddr, wData} <= head_entry;
            end
        end
    end

`ifdef RFWB_FWD_EN
    // Newest match wins: output stage first, then FIFO entries oldest to newest overwrite it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        if (we && (wAddr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[slot][ENT_W-1 -: ADDR_W] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[slot][DATA_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed bench for rf_write_buffer with a behavioural register file on the write port.
module tb_rf_write_buffer;
    import rfwb_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic [2:0]        count;
`ifdef RFWB_FWD_EN
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic over_seen = 1'b0;
    logic [DATA_W-1:0] rf [NUM_REGS];

    rf_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .drain_en (drain_en),
        .we       (we),
        .wAddr    (wAddr),
        .wData    (wData),
        .count    (count)
`ifdef RFWB_FWD_EN
        ,
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Register file model: captures the write port on the rising edge.
    always @(posedge clk) begin
        if (we) rf[wAddr] <= wData;
    end

    // Occupancy must never exceed DEPTH.
    always @(negedge clk) begin
        if (count > 3'(DEPTH)) over_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input int a, input int d);
        check({tag, "_we"}, 64'(we), 64'd1);
        check({tag, "_waddr"}, 64'(wAddr), 64'(a));
        check({tag, "_wdata"}, 64'(wData), 64'(d));
    endtask

    task automatic push_one(input int a, input int d);
        in_valid = 1'b1;
        in_addr  = ADDR_W'(a);
        in_data  = DATA_W'(d);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b0;
`ifdef RFWB_FWD_EN
        fwd_addr = '0;
`endif
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(wAddr), 64'd0);
        check("rst_wdata", 64'(wData), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Single request latency: accepted at N, on port after N+1, captured at N+2.
        drain_en = 1'b1;
        push_one(1, 'h1);
        check("lat_count_n", 64'(count), 64'd1);
        check("lat_we_n", 64'(we), 64'd0);
        tick();
        expect_write("lat_n1", 1, 'h1);
        check("lat_count_n1", 64'(count), 64'd0);
        tick();
        check("lat_we_n2", 64'(we), 64'd0);
        check("lat_rf1", 64'(rf[1]), 64'h1);

        // Fill with drain stalled, reject a fifth push, then drain in order.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(i, i);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        push_one(7, 'h7);
        check("full_reject_count", 64'(count), 64'd4);
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_write($sformatf("drain%0d", i), i, i);
        end
        tick();
        check("drain_idle_we", 64'(we), 64'd0);
        check("drain_idle_count", 64'(count), 64'd0);
        check("drain_hold_waddr", 64'(wAddr), 64'd4);
        push_one(7, 'h7);
        tick();
        expect_write("represent", 7, 'h7);
        tick();
        check("rf7", 64'(rf[7]), 64'h7);

        // Simultaneous push and pop at count 2.
        drain_en = 1'b0;
        push_one(2, 'h20);
        push_one(3, 'h30);
        check("pp_count_pre", 64'(count), 64'd2);
        drain_en = 1'b1;
        push_one(4, 'h40);
        check("pp_count", 64'(count), 64'd2);
        expect_write("pp0", 2, 'h20);
        tick();
        check("pp_count1", 64'(count), 64'd1);
        expect_write("pp1", 3, 'h30);
        tick();
        expect_write("pp2", 4, 'h40);
        tick();
        check("pp_idle_we", 64'(we), 64'd0);

        // Full with drain enabled and a held request: ready returns one cycle after the pop.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(i, 'h100 + i);
        in_valid = 1'b1;
        in_addr  = 3'd6;
        in_data  = 32'h66;
        drain_en = 1'b1;
        #1;
        check("fp_ready_pop_cycle", 64'(in_ready), 64'd0);
        tick();
        check("fp_count1", 64'(count), 64'd3);
        check("fp_ready_next", 64'(in_ready), 64'd1);
        expect_write("fp1", 1, 'h101);
        tick();
        in_valid = 1'b0;
        check("fp_count2", 64'(count), 64'd3);
        expect_write("fp2", 2, 'h102);
        tick();
        expect_write("fp3", 3, 'h103);
        tick();
        expect_write("fp4", 4, 'h104);
        tick();
        expect_write("fp6", 6, 'h66);
        check("fp_count_end", 64'(count), 64'd0);
        tick();
        check("fp_idle_we", 64'(we), 64'd0);

        // Reset mid-drain with entries pending.
        drain_en = 1'b0;
        push_one(5, 'h55);
        push_one(6, 'h56);
        push_one(7, 'h57);
        drain_en = 1'b1;
        tick();
        expect_write("mr_first", 5, 'h55);
        check("mr_count_pre", 64'(count), 64'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_we_async", 64'(we), 64'd0);
        check("mr_count_async", 64'(count), 64'd0);
        check("mr_ready", 64'(in_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_no_stale%0d", i), 64'(we), 64'd0);
        end
        check("mr_rf7_kept", 64'(rf[7]), 64'h7);
        check("mr_count_post", 64'(count), 64'd0);

`ifdef RFWB_FWD_EN
        // Forwarding: newest pending value for an address.
        drain_en = 1'b0;
        push_one(5, 'hA);
        push_one(5, 'hB);
        fwd_addr = 3'd5;
        #1;
        check("fwd_hit5", 64'(fwd_hit), 64'd1);
        check("fwd_data5", 64'(fwd_data), 64'hB);
        fwd_addr = 3'd6;
        #1;
        check("fwd_hit6", 64'(fwd_hit), 64'd0);
        check("fwd_data6", 64'(fwd_data), 64'h0);
        fwd_addr = 3'd5;
        drain_en = 1'b1;
        tick();
        check("fwd_mix_hit", 64'(fwd_hit), 64'd1);
        check("fwd_mix_data", 64'(fwd_data), 64'hB);
        tick();
        check("fwd_stage_hit", 64'(fwd_hit), 64'd1);
        check("fwd_stage_data", 64'(fwd_data), 64'hB);
        drain_en = 1'b0;
        tick();
        check("fwd_none_hit", 64'(fwd_hit), 64'd0);
        check("fwd_none_data", 64'(fwd_data), 64'h0);
`endif

        check("count_bound", 64'(over_seen), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
